// File: rtl/mod_n_down_counter.sv
// Loadable modulo-MOD down counter (MOD-1..0) clocked on the falling edge of x, with registered
// one-cycle borrow pulse on wrap and sticky out-of-range-load flag. Latency: 1 falling edge; no backpressure.
module mod_n_down_counter #(
   parameter int WIDTH = 3,
   parameter int MOD   = 8
) (
   input  logic             x,
   input  logic             rd,
   input  logic             en,
   input  logic             bin,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             z,
   output logic             err
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             bor_q, bor_d;
   logic             err_q, err_d;
   logic             din_ok;
   logic             cnt_legal;

   assign din_ok    = (32'(din)   < 32'(MOD));
   assign cnt_legal = (32'(cnt_q) < 32'(MOD));

   // Priority: load, then count, then hold. Borrow is cleared on every edge that does not wrap.
   always_comb begin
      cnt_d = cnt_q;
      bor_d = 1'b0;
      err_d = err_q;
      if (ld) begin
         if (din_ok) begin
            cnt_d = din;
         end else begin
            cnt_d = TOP;
            err_d = 1'b1;
         end
      end else if (en && bin) begin
         case (cnt_q)
            '0: begin
               cnt_d = TOP;
               bor_d = 1'b1;
            end
            default: begin
               // Codes >= MOD cannot be reached through load; recover to zero if seen.
               if (cnt_legal) cnt_d = cnt_q - ONE;
               else           cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(negedge x or negedge rd) begin
      if (!rd) begin
         cnt_q <= '0;
         bor_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         bor_q <= bor_d;
         err_q <= err_d;
      end
   end

   assign q   = cnt_q;
   assign z   = bor_q;
   assign err = err_q;

endmodule
